// File: rtl/uart_host_model_if.sv
// uart_host_model_if: host-side UART model bus (TX handshake, serial lines, expected-byte FIFO, RX results).
interface uart_host_model_if #(parameter int DATA_BITS = 8);
  logic [DATA_BITS-1:0] tx_data;
  logic tx_valid;
  logic tx_ready;
  logic host_tx;
  logic host_rx;
  logic [DATA_BITS-1:0] exp_data;
  logic exp_valid;
  logic exp_ready;
  logic [DATA_BITS-1:0] rx_data;
  logic rx_valid;
  logic rx_match;
  logic rx_err;
  logic [31:0] pass_count;
  logic [31:0] fail_count;
  logic timeout;
  modport master (
    output tx_data, tx_valid, host_rx, exp_data, exp_valid,
    input  tx_ready, host_tx, exp_ready, rx_data, rx_valid, rx_match, rx_err, pass_count, fail_count, timeout
  );
  modport slave (
    input  tx_data, tx_valid, host_rx, exp_data, exp_valid,
    output tx_ready, host_tx, exp_ready, rx_data, rx_valid, rx_match, rx_err, pass_count, fail_count, timeout
  );
endinterface

// File: rtl/uart_host_model.sv
// uart_host_model: UART host model -- serialises bytes onto host_tx, checks host_rx frames against an expected-byte FIFO.
// Optional RX watchdog enabled by macro UART_HOST_TIMEOUT_EN.
module uart_host_model #(
  parameter int CLOCK_FREQ     = 50_000_000,
  parameter int BAUD_RATE      = 10_000_000,
  parameter int DATA_BITS      = 8,
  parameter int PARITY         = 0,
  parameter int EXP_DEPTH      = 16,
  parameter int TX_GAP         = 300,
  parameter int TIMEOUT_CYCLES = 100_000
) (
  input logic clk,
  input logic rst,
  uart_host_model_if.slave bus
);
  localparam int CPB = CLOCK_FREQ / BAUD_RATE;
  localparam int AW = $clog2(EXP_DEPTH);
  typedef enum logic [2:0] {T_IDLE, T_START, T_DATA, T_PAR, T_STOP, T_GAP} tx_state_e;
  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PAR, R_STOP} rx_state_e;
  tx_state_e ts_q, ts_d;
  rx_state_e rs_q, rs_d;
  logic [31:0] tcnt_q, tcnt_d, rcnt_q, rcnt_d, pass_q, fail_q;
  logic [3:0] tbit_q, tbit_d, rbit_q, rbit_d;
  logic [DATA_BITS-1:0] tsh_q, tsh_d, rsh_q, rsh_d, rd_q;
  logic tpar_q, tpar_d, rpar_q, rpar_d;
  logic [1:0] sync_q;
  logic rdy_q, rv_q, rm_q, re_q;
  logic [DATA_BITS-1:0] mem_q [EXP_DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0] cnt_q;
  logic rx_s, t_end, r_end, tx_fire, push, pop, empty, done, err, match, wd_fire;
  logic [32:0] fail_sum;
  function automatic logic par_of(input logic [DATA_BITS-1:0] d);
    return (PARITY == 1) ? ~^d : ^d;
  endfunction
  assign rx_s = sync_q[1];
  assign t_end = tcnt_q == 32'(CPB - 1);
  assign r_end = rcnt_q == 32'(CPB - 1);
  // rdy_q keeps both ready outputs low through reset and for its release edge
  assign bus.tx_ready = rdy_q && ts_q == T_IDLE;
  assign bus.exp_ready = rdy_q && cnt_q != (AW+1)'(EXP_DEPTH);
  assign tx_fire = bus.tx_valid && bus.tx_ready;
  assign push = bus.exp_valid && bus.exp_ready;
  assign empty = cnt_q == '0;
  assign pop = done && !empty;
  assign err = !rx_s || (PARITY != 0 && rpar_q != par_of(rsh_q));
  assign match = pop && !err && rsh_q == mem_q[rp_q];
  assign fail_sum = {1'b0, fail_q} + 33'(done && !match) + 33'(wd_fire);
  assign bus.host_tx = ts_q == T_START ? 1'b0 : ts_q == T_DATA ? tsh_q[0] : ts_q == T_PAR ? tpar_q : 1'b1;
  assign bus.rx_data = rd_q;
  assign bus.rx_valid = rv_q;
  assign bus.rx_match = rm_q;
  assign bus.rx_err = re_q;
  assign bus.pass_count = pass_q;
  assign bus.fail_count = fail_q;
  always_comb begin
    ts_d = ts_q;
    tcnt_d = ts_q == T_IDLE ? '0 : tcnt_q + 32'd1;
    tbit_d = tbit_q;
    tsh_d = tsh_q;
    tpar_d = tpar_q;
    case (ts_q)
      T_IDLE: if (tx_fire) begin
        ts_d = T_START;
        tsh_d = bus.tx_data;
        tpar_d = par_of(bus.tx_data);
      end
      T_START: if (t_end) begin
        ts_d = T_DATA;
        tcnt_d = '0;
        tbit_d = '0;
      end
      T_DATA: if (t_end) begin
        tcnt_d = '0;
        tsh_d = tsh_q >> 1;
        tbit_d = tbit_q + 4'd1;
        if (tbit_q == 4'(DATA_BITS - 1)) ts_d = PARITY != 0 ? T_PAR : T_STOP;
      end
      T_PAR: if (t_end) begin
        tcnt_d = '0;
        ts_d = T_STOP;
      end
      T_STOP: if (t_end) begin
        tcnt_d = '0;
        ts_d = TX_GAP != 0 ? T_GAP : T_IDLE;
      end
      T_GAP: if (tcnt_q == 32'(TX_GAP - 1)) ts_d = T_IDLE;
      default: ts_d = T_IDLE;
    endcase
  end
  // start is confirmed CPB/2 cycles after detection, so every later sample lands mid-bit
  always_comb begin
    rs_d = rs_q;
    rcnt_d = rs_q == R_IDLE ? '0 : rcnt_q + 32'd1;
    rbit_d = rbit_q;
    rsh_d = rsh_q;
    rpar_d = rpar_q;
    done = 1'b0;
    case (rs_q)
      R_IDLE: if (!rx_s) rs_d = R_START;
      R_START: if (rcnt_q == 32'(CPB / 2)) begin
        rcnt_d = '0;
        rbit_d = '0;
        rs_d = rx_s ? R_IDLE : R_DATA;
      end
      R_DATA: if (r_end) begin
        rcnt_d = '0;
        rsh_d = {rx_s, rsh_q[DATA_BITS-1:1]};
        rbit_d = rbit_q + 4'd1;
        if (rbit_q == 4'(DATA_BITS - 1)) rs_d = PARITY != 0 ? R_PAR : R_STOP;
      end
      R_PAR: if (r_end) begin
        rcnt_d = '0;
        rpar_d = rx_s;
        rs_d = R_STOP;
      end
      R_STOP: if (r_end) begin
        done = 1'b1;
        rs_d = R_IDLE;
      end
      default: rs_d = R_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      ts_q <= T_IDLE;
      rs_q <= R_IDLE;
      tcnt_q <= '0;
      rcnt_q <= '0;
      tbit_q <= '0;
      rbit_q <= '0;
      tsh_q <= '0;
      rsh_q <= '0;
      tpar_q <= 1'b0;
      rpar_q <= 1'b0;
      sync_q <= 2'b11;
      rdy_q <= 1'b0;
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
      rd_q <= '0;
      rv_q <= 1'b0;
      rm_q <= 1'b0;
      re_q <= 1'b0;
      pass_q <= '0;
      fail_q <= '0;
    end else begin
      ts_q <= ts_d;
      rs_q <= rs_d;
      tcnt_q <= tcnt_d;
      rcnt_q <= rcnt_d;
      tbit_q <= tbit_d;
      rbit_q <= rbit_d;
      tsh_q <= tsh_d;
      rsh_q <= rsh_d;
      tpar_q <= tpar_d;
      rpar_q <= rpar_d;
      sync_q <= {sync_q[0], bus.host_rx};
      rdy_q <= 1'b1;
      wp_q <= wp_q + AW'(push);
      rp_q <= rp_q + AW'(pop);
      cnt_q <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
      if (done) rd_q <= rsh_q;
      rv_q <= done;
      rm_q <= match;
      re_q <= done && err;
      pass_q <= pass_q + 32'(match && pass_q != '1);
      fail_q <= fail_sum[32] ? '1 : fail_sum[31:0];
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= bus.exp_data;
  end
`ifdef UART_HOST_TIMEOUT_EN
  logic [31:0] wd_q, wd_d;
  logic to_q, wd_on;
  assign wd_on = !empty && rs_q == R_IDLE && !to_q;
  assign wd_d = wd_on ? wd_q + 32'd1 : '0;
  assign wd_fire = wd_on && wd_q == 32'(TIMEOUT_CYCLES - 1);
  assign bus.timeout = to_q;
  always_ff @(posedge clk) begin
    if (!rst) begin
      wd_q <= '0;
      to_q <= 1'b0;
    end else begin
      wd_q <= wd_d;
      to_q <= to_q || wd_fire;
    end
  end
`else
  assign wd_fire = 1'b0;
  assign bus.timeout = 1'b0;
`endif
endmodule

// File: tb/tb_uart_host_model.sv
// tb_uart_host_model: u0 (defaults, host_tx looped to host_rx) and u1 (even parity, serial driven by the bench)
// checked against a queue-based model of the expected-byte FIFO and pass/fail counts.
module tb_uart_host_model;
  localparam int CPB = 5;
  typedef struct packed {logic [7:0] d; logic m; logic e;} rx_t;
  logic clk = 1'b0;
  logic rst0, rst1, drv1;
  int errors = 0;
  int checks = 0;
  logic [7:0] expq0[$];
  logic [7:0] expq1[$];
  rx_t mq0[$];
  rx_t mq1[$];
  int pass0 = 0, fail0 = 0, pass1 = 0, fail1 = 0;
  always #5 clk = ~clk;
  uart_host_model_if #(.DATA_BITS(8)) if0 ();
  uart_host_model_if #(.DATA_BITS(8)) if1 ();
  uart_host_model u0 (.clk(clk), .rst(rst0), .bus(if0));
  uart_host_model #(.PARITY(2), .TIMEOUT_CYCLES(1000)) u1 (.clk(clk), .rst(rst1), .bus(if1));
  assign if0.host_rx = if0.host_tx;
  assign if1.host_rx = drv1;
  always @(negedge clk) begin
    if (if0.rx_valid) mq0.push_back(rx_t'{d: if0.rx_data, m: if0.rx_match, e: if0.rx_err});
    if (if1.rx_valid) mq1.push_back(rx_t'{d: if1.rx_data, m: if1.rx_match, e: if1.rx_err});
  end
  initial begin
    #3000000;
    $display("FAIL global_timeout observed=stuck expected=finish");
    $fatal(1, "simulation bound expired");
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic push(input int u, input logic [7:0] d);
    logic rdy;
    @(negedge clk);
    rdy = (u == 0 ? expq0.size() : expq1.size()) < 16;
    if (u == 0) begin
      chk("exp_ready0", if0.exp_ready, rdy);
      if0.exp_data = d;
      if0.exp_valid = 1'b1;
    end else begin
      chk("exp_ready1", if1.exp_ready, rdy);
      if1.exp_data = d;
      if1.exp_valid = 1'b1;
    end
    @(posedge clk);
    #1;
    if0.exp_valid = 1'b0;
    if1.exp_valid = 1'b0;
    if (rdy && u == 0) expq0.push_back(d);
    if (rdy && u != 0) expq1.push_back(d);
  endtask
  task automatic send0(input logic [7:0] d);
    int n = 0;
    @(negedge clk);
    while (!if0.tx_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("tx_ready_wait", if0.tx_ready, 1);
    if0.tx_data = d;
    if0.tx_valid = 1'b1;
    @(posedge clk);
    #1;
    if0.tx_valid = 1'b0;
  endtask
  task automatic drive1(input logic [7:0] d, input logic bad_par, input logic bad_stop);
    logic [10:0] bits;
    bits = {~bad_stop, (^d) ^ bad_par, d, 1'b0};
    @(negedge clk);
    for (int i = 0; i < 11; i++) begin
      drv1 = bits[i];
      repeat (CPB) @(negedge clk);
    end
    drv1 = 1'b1;
  endtask
  task automatic expect_rx(input int u, input logic [7:0] d, input logic e, input string tag);
    logic m;
    int n = 0;
    rx_t r;
    if (u == 0) begin
      m = expq0.size() != 0 && !e && expq0[0] == d;
      if (expq0.size() != 0) void'(expq0.pop_front());
      if (m) pass0++; else fail0++;
    end else begin
      m = expq1.size() != 0 && !e && expq1[0] == d;
      if (expq1.size() != 0) void'(expq1.pop_front());
      if (m) pass1++; else fail1++;
    end
    while ((u == 0 ? mq0.size() : mq1.size()) == 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    chk({tag, "_pulses"}, u == 0 ? mq0.size() : mq1.size(), 1);
    if ((u == 0 ? mq0.size() : mq1.size()) != 0) begin
      r = u == 0 ? mq0.pop_front() : mq1.pop_front();
      chk({tag, "_data"}, r.d, d);
      chk({tag, "_match"}, r.m, m);
      chk({tag, "_err"}, r.e, e);
    end
    mq0.delete();
    mq1.delete();
    chk({tag, "_pass"}, u == 0 ? if0.pass_count : if1.pass_count, u == 0 ? pass0 : pass1);
    chk({tag, "_fail"}, u == 0 ? if0.fail_count : if1.fail_count, u == 0 ? fail0 : fail1);
  endtask
  initial begin
    logic [7:0] b, d2;
    logic [9:0] fb;
    int mism, lowrun, f, n, mode;
    bit high_seen;
    rst0 = 1'b0;
    rst1 = 1'b0;
    drv1 = 1'b1;
    if0.tx_valid = 1'b0;
    if0.tx_data = '0;
    if0.exp_valid = 1'b0;
    if0.exp_data = '0;
    if1.tx_valid = 1'b0;
    if1.tx_data = '0;
    if1.exp_valid = 1'b0;
    if1.exp_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_host_tx", if0.host_tx, 1);
    chk("rst_tx_ready", if0.tx_ready, 0);
    chk("rst_exp_ready", if0.exp_ready, 0);
    chk("rst_rx_valid", if0.rx_valid, 0);
    chk("rst_rx_match", if0.rx_match, 0);
    chk("rst_rx_err", if0.rx_err, 0);
    chk("rst_rx_data", if0.rx_data, 0);
    chk("rst_pass", if0.pass_count, 0);
    chk("rst_fail", if0.fail_count, 0);
    chk("rst_timeout", if0.timeout, 0);
    chk("rst_tx_ready1", if1.tx_ready, 0);
    rst0 = 1'b1;
    rst1 = 1'b1;
    @(negedge clk);
    chk("rel_tx_ready", if0.tx_ready, 1);
    chk("rel_exp_ready", if0.exp_ready, 1);
    push(0, 8'h61);
    send0(8'h61);
    fb = {1'b1, 8'h61, 1'b0};
    mism = 0;
    lowrun = 0;
    high_seen = 1'b0;
    for (int i = 0; i < 10 * CPB; i++) begin
      @(negedge clk);
      if (if0.host_tx !== fb[i / CPB]) mism++;
      if (if0.host_tx === 1'b1) high_seen = 1'b1;
      if (!high_seen) lowrun++;
    end
    chk("tx_wave_mismatches", mism, 0);
    chk("start_low_cycles", lowrun, CPB);
    expect_rx(0, 8'h61, 1'b0, "f61");
    push(0, 8'h62);
    send0(8'h63);
    expect_rx(0, 8'h63, 1'b0, "f63");
    for (int i = 0; i < 16; i++) push(0, 8'h10 + 8'(i));
    @(negedge clk);
    chk("full_exp_ready", if0.exp_ready, 0);
    push(0, 8'hee);
    for (int i = 0; i < 16; i++) begin
      send0(8'h10 + 8'(i));
      expect_rx(0, 8'h10 + 8'(i), 1'b0, "burst");
    end
    chk("drained_exp_ready", if0.exp_ready, 1);
    send0(8'hee);
    expect_rx(0, 8'hee, 1'b0, "ignored17");
    for (int k = 0; k < 8; k++) begin
      b = 8'($urandom);
      mode = int'($urandom_range(0, 2));
      d2 = b ^ (8'd1 + 8'($urandom_range(0, 254)));
      if (mode == 0) push(0, b);
      if (mode == 1) push(0, d2);
      send0(b);
      expect_rx(0, b, 1'b0, "rand");
    end
    push(0, 8'h5a);
    send0(8'h5a);
    repeat (15) @(negedge clk);
    rst0 = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_host_tx", if0.host_tx, 1);
    @(negedge clk);
    chk("midrst_tx_ready", if0.tx_ready, 0);
    chk("midrst_exp_ready", if0.exp_ready, 0);
    chk("midrst_pass", if0.pass_count, 0);
    chk("midrst_fail", if0.fail_count, 0);
    expq0.delete();
    pass0 = 0;
    fail0 = 0;
    repeat (3) @(negedge clk);
    mq0.delete();
    rst0 = 1'b1;
    @(negedge clk);
    chk("midrst_rel_ready", if0.tx_ready, 1);
    repeat (100) @(negedge clk);
    chk("midrst_no_partial", mq0.size(), 0);
    push(0, 8'ha5);
    send0(8'ha5);
    expect_rx(0, 8'ha5, 1'b0, "postrst");
    push(1, 8'h0d);
    drive1(8'h0d, 1'b1, 1'b0);
    expect_rx(1, 8'h0d, 1'b1, "badpar");
    push(1, 8'h0d);
    drive1(8'h0d, 1'b0, 1'b0);
    expect_rx(1, 8'h0d, 1'b0, "goodpar");
    push(1, 8'h77);
    drive1(8'h77, 1'b0, 1'b1);
    expect_rx(1, 8'h77, 1'b1, "framing");
    repeat (20) @(negedge clk);
    drv1 = 1'b0;
    repeat (3) @(negedge clk);
    drv1 = 1'b1;
    repeat (100) @(negedge clk);
    chk("glitch_no_rx", mq1.size(), 0);
    chk("glitch_fail", if1.fail_count, fail1);
    f = fail1;
    push(1, 8'h3e);
    n = 0;
    while (!if1.timeout && n < 1200) begin
      @(posedge clk);
      #1;
      n++;
    end
`ifdef UART_HOST_TIMEOUT_EN
    chk("timeout_cycle", n, 1000);
    chk("timeout_set", if1.timeout, 1);
    chk("timeout_fail", if1.fail_count, f + 1);
    repeat (500) @(negedge clk);
    chk("timeout_sticky", if1.timeout, 1);
    chk("timeout_fail_once", if1.fail_count, f + 1);
`else
    chk("timeout_off", if1.timeout, 0);
    chk("timeout_off_fail", if1.fail_count, f);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
